// File: rtl/seg7_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_if                                                    |
// | Purpose  : Bundle of the hex 7-segment scanner's data inputs and display   |
// |            outputs.                                                        |
// | Signals  : en      scan enable                                             |
// |            din     4*NDIG hex nibbles, din[4i+3:4i] -> digit i             |
// |            dp      per-digit decimal point                                 |
// |            blank   per-digit force-dark                                    |
// |            lz_sup  leading-zero suppression enable                         |
// |            RAZR    digit enables (one-hot when lit)                        |
// |            SEG     SEG[0..6]=a..g, SEG[7]=dp                               |
// |            frame   1-clk pulse when a new input snapshot is taken          |
// | Modports : master (drives inputs), slave (the scanner)                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface seg7_scan_if #(
    parameter int NDIG = 8
) ();
    logic              en;
    logic [4*NDIG-1:0] din;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   blank;
    logic              lz_sup;
    logic [NDIG-1:0]   RAZR;
    logic [7:0]        SEG;
    logic              frame;

    modport master (
        output en, din, dp, blank, lz_sup,
        input  RAZR, SEG, frame
    );

    modport slave (
        input  en, din, dp, blank, lz_sup,
        output RAZR, SEG, frame
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan                                                       |
// | Purpose  : Multiplexed hex 7-segment scanner for NDIG digits with          |
// |            selectable polarity, per-digit DP/blank, leading-zero           |
// |            suppression, anti-ghost blanking gap and a frame-coherent       |
// |            input snapshot.                                                 |
// | Ports    : clk   clock                                                     |
// |            rst   asynchronous reset, active-high                           |
// |            bus   seg7_scan_if.slave (en, din, dp, blank, lz_sup in;        |
// |                  RAZR, SEG, frame out)                                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan #(
    parameter int NDIG        = 8,
    parameter int CLK_DIV     = 3125,
    parameter int BLANK_CYC   = 16,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seg7_scan_if.slave bus
);

    localparam int c_IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int c_CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int c_CNTW    = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNTW-1:0] c_SHOW_LAST  = c_CNTW'(CLK_DIV - 1);
    localparam logic [c_CNTW-1:0] c_BLANK_LAST = c_CNTW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [c_IDXW-1:0] c_IDX_LAST   = c_IDXW'(NDIG - 1);
    localparam bit                c_HAS_BLANK  = (BLANK_CYC > 0);

    // Inactive levels; lit values are built active-high and XORed with these.
    localparam logic [7:0]      c_SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [NDIG-1:0] c_DIG_OFF = DIG_ACT_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNTW-1:0]   r_cnt;
    logic [c_IDXW-1:0]   r_idx;
    logic [4*NDIG-1:0]   r_din;
    logic [NDIG-1:0]     r_dp;
    logic [NDIG-1:0]     r_blank;
    logic                r_lz;
    logic [NDIG-1:0]     r_razr;
    logic [7:0]          r_seg;
    logic                r_frame;

    logic                w_show_end;
    logic                w_blank_end;
    logic                w_wrap;
    logic                w_take;
    logic [c_IDXW-1:0]   w_idx_inc;
    logic [c_IDXW-1:0]   w_show_idx;
    logic [4*NDIG-1:0]   w_din_v;
    logic [NDIG-1:0]     w_dp_v;
    logic [NDIG-1:0]     w_blank_v;
    logic                w_lz_v;
    logic                w_run;
    logic [NDIG-1:0]     w_sup;
    logic [3:0]          w_nib;
    logic                w_dark;
    logic [7:0]          w_seg_lit;
    logic [NDIG-1:0]     w_razr_lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Outputs are registered together with the state they belong to, so the
    // value for a slot being entered is computed from the post-edge view: the
    // index it will show and the snapshot it will see (which may be captured
    // on this very edge when entering straight into SHOW).
    always_comb begin
        w_show_end  = (r_state == S_SHOW)  && (r_cnt == c_SHOW_LAST);
        w_blank_end = (r_state == S_BLANK) && (r_cnt == c_BLANK_LAST);
        w_wrap      = w_show_end && (r_idx == c_IDX_LAST);
        w_take      = bus.en && ((r_state == S_IDLE) || w_wrap);
        w_idx_inc   = w_wrap ? '0 : r_idx + 1'b1;

        case (r_state)
            S_IDLE:  w_show_idx = '0;
            S_SHOW:  w_show_idx = w_idx_inc;
            default: w_show_idx = r_idx;
        endcase

        w_din_v   = w_take ? bus.din    : r_din;
        w_dp_v    = w_take ? bus.dp     : r_dp;
        w_blank_v = w_take ? bus.blank  : r_blank;
        w_lz_v    = w_take ? bus.lz_sup : r_lz;

        // A digit is suppressed while the run of zero nibbles without DP,
        // counted from the most significant digit down, is still unbroken.
        w_sup = '0;
        w_run = w_lz_v;
        for (int i = NDIG - 1; i >= 1; i--) begin
            w_run    = w_run && (w_din_v[4*i +: 4] == 4'h0) && !w_dp_v[i];
            w_sup[i] = w_run;
        end

        w_nib      = w_din_v[{w_show_idx, 2'b00} +: 4];
        w_dark     = w_blank_v[w_show_idx] | w_sup[w_show_idx];
        w_seg_lit  = w_dark ? 8'h00 : {w_dp_v[w_show_idx], hex7(w_nib)};
        w_razr_lit = {{(NDIG-1){1'b0}}, 1'b1} << w_show_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_din   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_lz    <= 1'b0;
            r_razr  <= c_DIG_OFF;
            r_seg   <= c_SEG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= 1'b0;

            if (w_take) begin
                r_din   <= bus.din;
                r_dp    <= bus.dp;
                r_blank <= bus.blank;
                r_lz    <= bus.lz_sup;
            end

            if (!bus.en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_razr  <= c_DIG_OFF;
                r_seg   <= c_SEG_OFF;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_frame <= 1'b1;
                        if (c_HAS_BLANK) begin
                            r_state <= S_BLANK;
                            r_razr  <= c_DIG_OFF;
                            r_seg   <= c_SEG_OFF;
                        end else begin
                            r_state <= S_SHOW;
                            r_razr  <= w_razr_lit ^ c_DIG_OFF;
                            r_seg   <= w_seg_lit ^ c_SEG_OFF;
                        end
                    end

                    S_BLANK: begin
                        if (w_blank_end) begin
                            r_state <= S_SHOW;
                            r_cnt   <= '0;
                            r_razr  <= w_razr_lit ^ c_DIG_OFF;
                            r_seg   <= w_seg_lit ^ c_SEG_OFF;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    S_SHOW: begin
                        if (w_show_end) begin
                            r_idx   <= w_idx_inc;
                            r_cnt   <= '0;
                            r_frame <= w_wrap;
                            if (c_HAS_BLANK) begin
                                r_state <= S_BLANK;
                                r_razr  <= c_DIG_OFF;
                                r_seg   <= c_SEG_OFF;
                            end else begin
                                r_state <= S_SHOW;
                                r_razr  <= w_razr_lit ^ c_DIG_OFF;
                                r_seg   <= w_seg_lit ^ c_SEG_OFF;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_razr  <= c_DIG_OFF;
                        r_seg   <= c_SEG_OFF;
                    end
                endcase
            end
        end
    end

    assign bus.RAZR  = r_razr;
    assign bus.SEG   = r_seg;
    assign bus.frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg7_scan                                                    |
// | Purpose  : Self-checking bench for seg7_scan. dut_a: 4 digits, CLK_DIV=4,  |
// |            BLANK_CYC=2, active-low. dut_b: same but BLANK_CYC=0 and        |
// |            active-high.                                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg7_scan;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_if #(.NDIG(4)) a_if ();
    seg7_scan_if #(.NDIG(4)) b_if ();

    seg7_scan #(.NDIG(4), .CLK_DIV(4), .BLANK_CYC(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(a_if));

    seg7_scan #(.NDIG(4), .CLK_DIV(4), .BLANK_CYC(0), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(b_if));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [11:0] exp_q [$];   // {RAZR, SEG} expected per lit slot of dut_a
    logic        mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        exp_q.push_back({4'b1110, s0});
        exp_q.push_back({4'b1101, s1});
        exp_q.push_back({4'b1011, s2});
        exp_q.push_back({4'b0111, s3});
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] p,
                          input logic [3:0] b, input logic lz);
        a_if.din    = d;
        a_if.dp     = p;
        a_if.blank  = b;
        a_if.lz_sup = lz;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_if.frame && n < 200);
        if (!a_if.frame) chk("wait_frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_razr(input logic [3:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_if.RAZR !== v && n < 200);
        if (a_if.RAZR !== v) chk("wait_razr_timeout", {28'd0, a_if.RAZR}, {28'd0, v});
    endtask

    // Inputs set right after a frame pulse are captured at the next pulse,
    // so the expectations pushed here belong to the following frame.
    task automatic apply_next(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                              input logic lz, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        wait_frame();
        set_in(d, p, b, lz);
        push_frame(s0, s1, s2, s3);
    endtask

    // ---------------- monitor / scoreboard for dut_a ----------------
    logic [3:0]  prev_razr  = 4'hF;
    logic [11:0] cur_exp;
    logic        has_exp    = 1'b0;
    logic        seen       = 1'b0;
    logic        have_frame = 1'b0;
    int          lit_len    = 0;
    int          dark_len   = 0;
    int          last_frame = 0;

    always @(negedge clk) begin
        if (rst || !mon_on) begin
            seen       = 1'b0;
            have_frame = 1'b0;
            has_exp    = 1'b0;
            lit_len    = 0;
            dark_len   = 0;
            prev_razr  = 4'hF;
        end else begin
            if (a_if.frame) begin
                if (have_frame) chk("frame_period", cyc - last_frame, 24);
                chk("frame_in_dark", {28'd0, a_if.RAZR}, 32'hF);
                have_frame = 1'b1;
                last_frame = cyc;
            end
            if (a_if.RAZR != 4'hF) begin
                if (a_if.RAZR != prev_razr) begin
                    if (seen) chk("dark_gap", dark_len, 2);
                    if (a_if.RAZR == 4'b1110 && have_frame)
                        chk("frame_to_digit0", cyc - last_frame, 2);
                    if (exp_q.size() > 0) begin
                        cur_exp = exp_q.pop_front();
                        has_exp = 1'b1;
                        chk("slot", {20'd0, a_if.RAZR, a_if.SEG}, {20'd0, cur_exp});
                    end else begin
                        has_exp = 1'b0;
                    end
                    lit_len = 0;
                end else if (has_exp) begin
                    chk("slot_hold", {20'd0, a_if.RAZR, a_if.SEG}, {20'd0, cur_exp});
                end
                lit_len++;
                dark_len = 0;
                seen     = 1'b1;
            end else begin
                if (prev_razr != 4'hF && seen) chk("lit_len", lit_len, 4);
                dark_len++;
            end
            prev_razr = a_if.RAZR;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] s0;
        logic [3:0] nb;
        int         bad_a;
        int         bad_b;

        rst = 1'b1;
        set_in(16'h0, 4'h0, 4'h0, 1'b0);
        a_if.en     = 1'b0;
        b_if.en     = 1'b0;
        b_if.din    = 16'h0;
        b_if.dp     = 4'h0;
        b_if.blank  = 4'h0;
        b_if.lz_sup = 1'b0;

        // Reset state of both polarities
        repeat (3) @(negedge clk);
        chk("rst_a_razr",  {28'd0, a_if.RAZR}, 32'hF);
        chk("rst_a_seg",   {24'd0, a_if.SEG},  32'hFF);
        chk("rst_a_frame", {31'd0, a_if.frame}, 32'd0);
        chk("rst_b_razr",  {28'd0, b_if.RAZR}, 32'h0);
        chk("rst_b_seg",   {24'd0, b_if.SEG},  32'h0);
        chk("rst_b_frame", {31'd0, b_if.frame}, 32'd0);

        // Released with en=0: nothing moves for 100 clocks
        rst   = 1'b0;
        bad_a = 0;
        bad_b = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_if.RAZR !== 4'hF || a_if.SEG !== 8'hFF || a_if.frame !== 1'b0) bad_a++;
            if (b_if.RAZR !== 4'h0 || b_if.SEG !== 8'h00 || b_if.frame !== 1'b0) bad_b++;
        end
        chk("idle_a_stable_bad_cycles", bad_a, 0);
        chk("idle_b_stable_bad_cycles", bad_b, 0);

        // Basic scan of 1234
        set_in(16'h1234, 4'h0, 4'h0, 1'b0);
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        mon_on  = 1'b1;
        a_if.en = 1'b1;

        // Digit-0 sweep 0..F, DP on odd values; upper digits 3,2,1 = 1,2,3
        for (int n = 0; n < 16; n++) begin
            nb = n[3:0];
            s0 = ~{nb[0], hex_tbl[nb]};
            apply_next({12'h123, nb}, {3'b000, nb[0]}, 4'h0, 1'b0, s0, 8'hB0, 8'hA4, 8'hF9);
        end

        // Leading-zero suppression and blanking
        apply_next(16'h0050, 4'h0, 4'h0, 1'b1, 8'hC0, 8'h92, 8'hFF, 8'hFF);
        apply_next(16'h0000, 4'h0, 4'h0, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        apply_next(16'h0000, 4'h8, 4'h0, 1'b1, 8'hC0, 8'hC0, 8'hC0, 8'h40);
        apply_next(16'h1234, 4'h1, 4'h2, 1'b1, 8'h19, 8'hFF, 8'hA4, 8'hF9);

        // Mid-frame change lands only in the next frame
        apply_next(16'h5678, 4'h0, 4'h0, 1'b0, 8'h80, 8'hF8, 8'h82, 8'h92);
        wait_frame();
        wait_razr(4'b1101);
        set_in(16'h9ABC, 4'h0, 4'h0, 1'b0);
        push_frame(8'hC6, 8'h83, 8'h88, 8'h90);

        // Let the last expected frame play out
        wait_frame();
        repeat (23) @(negedge clk);
        mon_on = 1'b0;
        chk("queue_empty", exp_q.size(), 0);

        // Drop en in digit 2's slot
        wait_razr(4'b1011);
        a_if.en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_off_razr",  {28'd0, a_if.RAZR}, 32'hF);
        chk("en_off_seg",   {24'd0, a_if.SEG},  32'hFF);
        chk("en_off_frame", {31'd0, a_if.frame}, 32'd0);
        @(negedge clk);
        a_if.en = 1'b1;
        @(negedge clk);
        chk("reen_frame", {31'd0, a_if.frame}, 32'd1);
        chk("reen_dark",  {28'd0, a_if.RAZR}, 32'hF);
        repeat (2) @(negedge clk);
        chk("reen_digit0_razr", {28'd0, a_if.RAZR}, 32'hE);
        chk("reen_digit0_seg",  {24'd0, a_if.SEG},  32'hC6);

        // Asynchronous reset while lit
        rst = 1'b1;
        #1;
        chk("async_rst_show_razr", {28'd0, a_if.RAZR}, 32'hF);
        chk("async_rst_show_seg",  {24'd0, a_if.SEG},  32'hFF);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the first BLANK cycle clears the frame pulse
        wait_frame();
        rst = 1'b1;
        #1;
        chk("async_rst_blank_frame", {31'd0, a_if.frame}, 32'd0);
        chk("async_rst_blank_razr",  {28'd0, a_if.RAZR},  32'hF);
        @(negedge clk);
        rst     = 1'b0;
        a_if.en = 1'b0;

        // Active-high polarity, no blanking gap
        b_if.din = 16'h00F0;
        @(negedge clk);
        b_if.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("b_razr",  {28'd0, b_if.RAZR}, {28'd0, 4'b0001 << (i / 4)});
            chk("b_seg",   {24'd0, b_if.SEG},  (i / 4 == 1) ? 32'h71 : 32'h3F);
            chk("b_frame", {31'd0, b_if.frame}, (i == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("b_frame_period", {31'd0, b_if.frame}, 32'd1);
        chk("b_wrap_razr",    {28'd0, b_if.RAZR},  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
